// File: rtl/mux_pkg.sv
// Shared definitions for the sequential N-to-1 multiplexer.
//   state_t     : FSM encoding (IDLE / MANUAL / SCAN)
//   MODE_*      : values of the mode input
//   dwell_w()   : width of a counter that must hold the value DWELL
package mux_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MANUAL = 2'd1,
        SCAN   = 2'd2
    } state_t;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    function automatic int unsigned dwell_w(input int unsigned dwell);
        return $clog2(dwell + 1);
    endfunction

endpackage

// File: rtl/mux_dwell_ctr.sv
// Dwell counter for scan mode: counts 0..DWELL-1 while run is high,
// holds while run is low, and returns to 0 on clr.
//   clk, rst_n : clock, asynchronous active-low reset
//   run        : advance the counter this cycle
//   clr        : force the counter to 0 (wins over run)
//   count      : current counter value
//   tick       : counter is at DWELL-1 and run is high (advance point)
module mux_dwell_ctr
    import mux_pkg::*;
#(
    parameter int unsigned DWELL = 100,
    parameter int unsigned CW    = dwell_w(DWELL)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          run,
    input  logic          clr,
    output logic [CW-1:0] count,
    output logic          tick
);

    logic [CW-1:0] r_count;
    logic          w_at_end;

    // Equality compare, so DWELL=1 ticks on every running cycle.
    assign w_at_end = (r_count == CW'(DWELL - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (run) begin
            r_count <= w_at_end ? '0 : r_count + CW'(1);
        end
    end

    assign count = r_count;
    assign tick  = run & w_at_end;

endmodule

// File: rtl/mux_n_to_1_seq.sv
// Registered N-to-1 multiplexer with manual select or automatic channel
// scanning with a programmable dwell time.
//   clk, rst_n : clock, asynchronous active-low reset
//   in_bus     : N channels of W bits, channel i at [i*W +: W]
//   sel        : manual channel select
//   mode       : 0 = manual, 1 = scan
//   en         : 0 pauses the block (outputs and dwell hold)
//   y          : registered selected data
//   cur_sel    : channel index currently driving y
//   y_valid    : y was sampled on an enabled cycle with a legal channel
//   wrap       : one-cycle pulse on the scan step from N-1 to 0
//   sel_err    : one-cycle pulse when manual sel >= N
module mux_n_to_1_seq
    import mux_pkg::*;
#(
    parameter int unsigned N     = 4,
    parameter int unsigned W     = 1,
    parameter int unsigned DWELL = 100,
    parameter int unsigned SELW  = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N*W-1:0]    in_bus,
    input  logic [SELW-1:0]   sel,
    input  logic              mode,
    input  logic              en,
    output logic [W-1:0]      y,
    output logic [SELW-1:0]   cur_sel,
    output logic              y_valid,
    output logic              wrap,
    output logic              sel_err
);

    localparam int unsigned     CW   = dwell_w(DWELL);
    localparam logic [SELW-1:0] LAST = SELW'(N - 1);

    state_t          r_state, w_state_nxt;
    logic [W-1:0]    r_y, w_y_nxt, w_pick;
    logic [SELW-1:0] r_cur_sel, w_cur_nxt, w_scan_nxt, w_idx;
    logic            r_wrap, w_wrap_nxt;
    logic            r_sel_err, w_err_nxt;
    logic            w_sel_ok, w_run, w_clr, w_tick;
    logic [CW-1:0]   w_count;
    logic            w_unused_count;

    // Dwell runs only while enabled in scan; manual mode discards partial dwell.
    assign w_run = en & (mode == MODE_SCAN);
    assign w_clr = en & (mode == MODE_MANUAL);

    mux_dwell_ctr #(
        .DWELL (DWELL),
        .CW    (CW)
    ) u_dwell (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (w_run),
        .clr   (w_clr),
        .count (w_count),
        .tick  (w_tick)
    );

    // Steering uses only tick; the count is kept for observation.
    assign w_unused_count = ^w_count;

    assign w_sel_ok   = (32'(sel) < N);
    assign w_scan_nxt = (r_cur_sel == LAST) ? '0 : r_cur_sel + SELW'(1);

    // Channel that will drive y next, so y and cur_sel always agree.
    assign w_idx = (mode == MODE_SCAN) ? (w_tick ? w_scan_nxt : r_cur_sel) : sel;

    // Channel select; an out-of-range index yields 0 and is never loaded.
    always_comb begin
        w_pick = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (w_idx == SELW'(i)) begin
                w_pick = in_bus[i*W +: W];
            end
        end
    end

    // Next state and next outputs; state is re-decoded from en/mode every cycle.
    always_comb begin
        w_state_nxt = IDLE;
        w_y_nxt     = r_y;
        w_cur_nxt   = r_cur_sel;
        w_wrap_nxt  = 1'b0;
        w_err_nxt   = 1'b0;

        if (en) begin
            w_state_nxt = (mode == MODE_SCAN) ? SCAN : MANUAL;
        end

        case (w_state_nxt)
            MANUAL: begin
                if (w_sel_ok) begin
                    w_cur_nxt = sel;
                    w_y_nxt   = w_pick;
                end else begin
                    w_err_nxt = 1'b1;
                end
            end
            SCAN: begin
                if (w_tick) begin
                    w_cur_nxt  = w_scan_nxt;
                    w_wrap_nxt = (r_cur_sel == LAST);
                end
                w_y_nxt = w_pick;
            end
            default: ;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_y       <= '0;
            r_cur_sel <= '0;
            r_wrap    <= 1'b0;
            r_sel_err <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_y       <= w_y_nxt;
            r_cur_sel <= w_cur_nxt;
            r_wrap    <= w_wrap_nxt;
            r_sel_err <= w_err_nxt;
        end
    end

    assign y       = r_y;
    assign cur_sel = r_cur_sel;
    assign wrap    = r_wrap;
    assign sel_err = r_sel_err;
    // Valid after any enabled cycle except a rejected manual select.
    assign y_valid = (r_state != IDLE) & ~r_sel_err;

endmodule

// File: tb/tb_mux_n_to_1_seq.sv
// Self-checking bench for mux_n_to_1_seq: directed scenarios plus random
// traffic on two instances (N=4/W=1/DWELL=4 and N=3/W=8/DWELL=1).
module tb_mux_n_to_1_seq;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        en, mode;
    logic [3:0]  bus_a;
    logic [1:0]  sel_a;
    logic [23:0] bus_b;
    logic [1:0]  sel_b;

    logic        y_a;
    logic [1:0]  cur_a;
    logic        yv_a, wrap_a, err_a;
    logic [7:0]  y_b;
    logic [1:0]  cur_b;
    logic        yv_b, wrap_b, err_b;

    always #5 clk = ~clk;

    mux_n_to_1_seq #(.N(4), .W(1), .DWELL(4)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .in_bus(bus_a), .sel(sel_a), .mode(mode), .en(en),
        .y(y_a), .cur_sel(cur_a), .y_valid(yv_a), .wrap(wrap_a), .sel_err(err_a)
    );

    mux_n_to_1_seq #(.N(3), .W(8), .DWELL(1)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .in_bus(bus_b), .sel(sel_b), .mode(mode), .en(en),
        .y(y_b), .cur_sel(cur_b), .y_valid(yv_b), .wrap(wrap_b), .sel_err(err_b)
    );

    // Behavioural view of one mux: channel held, dwell cycles spent on it.
    typedef struct {
        int         cur;
        int         spent;
        logic [7:0] y;
        bit         valid;
        bit         wrap;
        bit         err;
    } model_t;

    model_t ma, mb;
    int     n_checks = 0;
    int     n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic model_t model_reset();
        model_t m;
        m.cur = 0; m.spent = 0; m.y = 8'h00; m.valid = 0; m.wrap = 0; m.err = 0;
        return m;
    endfunction

    function automatic logic [7:0] chan(input logic [31:0] bus, input int ch, input int w);
        logic [31:0] v;
        v = bus >> (ch * w);
        return 8'(v & ((32'd1 << w) - 32'd1));
    endfunction

    // One clock of the mux, from the rules: hold when disabled, load a legal
    // manual select, or spend one dwell cycle and move on after DWELL of them.
    function automatic model_t model_step(input model_t m, input int n, input int dwell,
                                          input int w, input logic [31:0] bus,
                                          input int sel, input bit md, input bit enable);
        model_t r = m;
        r.valid = 0; r.wrap = 0; r.err = 0;
        if (!enable) return r;
        if (!md) begin
            r.spent = 0;
            if (sel < n) begin
                r.cur = sel; r.y = chan(bus, sel, w); r.valid = 1;
            end else begin
                r.err = 1;
            end
        end else begin
            r.valid = 1;
            r.spent = m.spent + 1;
            if (r.spent == dwell) begin
                r.spent = 0;
                r.cur   = (m.cur + 1) % n;
                r.wrap  = (r.cur == 0);
            end
            r.y = chan(bus, r.cur, w);
        end
        return r;
    endfunction

    task automatic check_all();
        check("A.y",       32'(y_a),    32'(ma.y));
        check("A.cur_sel", 32'(cur_a),  32'(ma.cur));
        check("A.y_valid", 32'(yv_a),   32'(ma.valid));
        check("A.wrap",    32'(wrap_a), 32'(ma.wrap));
        check("A.sel_err", 32'(err_a),  32'(ma.err));
        check("B.y",       32'(y_b),    32'(mb.y));
        check("B.cur_sel", 32'(cur_b),  32'(mb.cur));
        check("B.y_valid", 32'(yv_b),   32'(mb.valid));
        check("B.wrap",    32'(wrap_b), 32'(mb.wrap));
        check("B.sel_err", 32'(err_b),  32'(mb.err));
    endtask

    // Advance one clock, update the models with the sampled inputs, check #1 later.
    task automatic cycle();
        @(posedge clk);
        if (rst_n) begin
            ma = model_step(ma, 4, 4, 1, 32'(bus_a), int'(sel_a), mode, en);
            mb = model_step(mb, 3, 1, 8, 32'(bus_b), int'(sel_b), mode, en);
        end
        #1;
        check_all();
    endtask

    // Reset asserted between edges must clear outputs without a clock.
    task automatic async_reset();
        #2 rst_n = 1'b0;
        #1;
        ma = model_reset();
        mb = model_reset();
        check_all();
        check("rst.y_a", 32'(y_a), 32'd0);
        cycle();
        cycle();
        rst_n = 1'b1;
    endtask

    task automatic wait_for_a(input int cur, input int spent, input int budget, input string tag);
        int k = 0;
        while (!(ma.cur == cur && (spent < 0 || ma.spent == spent)) && k < budget) begin
            cycle();
            k++;
        end
        if (k >= budget) check(tag, 32'd0, 32'd1);
    endtask

    initial begin
        int nw, k;
        en = 1'b0; mode = 1'b0; sel_a = 2'd0; sel_b = 2'd0;
        bus_a = 4'b0101;
        bus_b = {8'hCC, 8'hBB, 8'hAA};
        ma = model_reset();
        mb = model_reset();

        // Reset state
        #1 rst_n = 1'b0;
        #2 check_all();
        cycle();
        cycle();
        rst_n = 1'b1;

        // Manual sweep
        en = 1'b1; mode = 1'b0;
        for (int s = 0; s < 4; s++) begin
            sel_a = 2'(s);
            sel_b = 2'(s % 3);
            cycle();
            check("p1.y", 32'(y_a), (s % 2 == 0) ? 32'd1 : 32'd0);
            check("p1.cur", 32'(cur_a), 32'(s));
            repeat (24) cycle();
        end

        // Scan from reset, DWELL=4
        async_reset();
        mode = 1'b1;
        nw = 0;
        for (int e = 1; e <= 40; e++) begin
            cycle();
            check("p2.cur", 32'(cur_a), 32'((e / 4) % 4));
            if (wrap_a) nw++;
        end
        check("p2.wraps", 32'(nw), 32'd2);

        // Pause at count 2 on channel 1
        wait_for_a(1, 2, 64, "p3.wait");
        en = 1'b0;
        repeat (10) cycle();
        check("p3.cur_hold", 32'(cur_a), 32'd1);
        check("p3.valid", 32'(yv_a), 32'd0);
        en = 1'b1;
        k = 0;
        while (cur_a == 2'd1 && k < 10) begin
            cycle();
            k++;
        end
        check("p3.remaining", 32'(k), 32'd2);

        // Illegal manual select on the 3-channel instance
        mode = 1'b0; sel_a = 2'd0;
        sel_b = 2'd2;
        cycle();
        check("p4.y", 32'(y_b), 32'hCC);
        sel_b = 2'd3;
        cycle();
        check("p4.y_hold", 32'(y_b), 32'hCC);
        check("p4.valid", 32'(yv_b), 32'd0);
        check("p4.err", 32'(err_b), 32'd1);
        sel_b = 2'd2;
        cycle();
        check("p4.err_clear", 32'(err_b), 32'd0);

        // Reset mid-scan at channel 2
        mode = 1'b1;
        wait_for_a(2, -1, 40, "p5.wait");
        async_reset();
        cycle();
        check("p5.cur", 32'(cur_a), 32'd0);
        repeat (6) cycle();

        // Mode switch from channel 3
        wait_for_a(3, -1, 40, "p6.wait");
        mode = 1'b0; sel_a = 2'd1;
        cycle();
        check("p6.cur", 32'(cur_a), 32'd1);
        check("p6.y", 32'(y_a), 32'd0);
        mode = 1'b1;
        k = 0;
        while (cur_a != 2'd2 && k < 20) begin
            cycle();
            k++;
        end
        check("p6.dwell", 32'(k), 32'd4);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            en = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 15) == 0) mode = ~mode;
            sel_a = 2'($urandom_range(0, 3));
            sel_b = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) bus_a = 4'($urandom);
            if ($urandom_range(0, 3) == 0) bus_b = 24'($urandom);
            if ($urandom_range(0, 499) == 0) async_reset();
            else cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
